// File: rtl/ifu_fetch_pkg.sv
// Shared constants for the instruction fetch stage: reset defaults, the NOP
// pattern shown when no pair is valid, and the small credit counter type.
package ifu_fetch_pkg;

    localparam int          AW_DEF       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    // Counters for in-flight and buffered fetches never exceed 2.
    typedef logic [1:0] cnt_t;

endpackage

// File: rtl/ifu_buf.sv
// Two-entry synchronous FIFO with clear; entry 0 is always the head so the
// head output is a plain register with no read mux.
module ifu_buf
    import ifu_fetch_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output cnt_t         count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem1;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            mem1  <= '0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            if (do_pop) begin
                // Shift entry 1 forward; a simultaneous push lands behind it.
                if (do_push && (count == 2'd1)) head <= din;
                else                            head <= mem1;
                if (do_push && (count == 2'd2)) mem1 <= din;
            end else if (do_push) begin
                if (count == 2'd0) head <= din;
                else               mem1 <= din;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// RV32 instruction fetch: owns the PC, issues in-order word fetches under a
// two-credit limit, buffers responses and discards stale ones after a jump.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_addr,
    input  logic          hold_en,
    output logic          ibus_req,
    output logic [AW-1:0] ibus_addr,
    input  logic          ibus_gnt,
    input  logic          ibus_rvalid,
    input  logic [31:0]   ibus_rdata,
    output logic          inst_valid_o,
    output logic [31:0]   inst_o,
    output logic [AW-1:0] inst_addr_o
);

    logic [AW-1:0] pc;
    cnt_t          drop;
    cnt_t          aq_count;
    cnt_t          fifo_count;
    cnt_t          outst;
    logic [2:0]    credit;
    logic [AW-1:0] aq_head;
    logic [AW+31:0] fifo_head;
    logic          hs;
    logic          rsp;
    logic          rsp_keep;
    logic          pop;

    // In-flight fetches are the live ones waiting in the address queue plus
    // the stale ones still to be discarded.
    assign outst  = aq_count + drop;
    assign credit = {1'b0, outst} + {1'b0, fifo_count};

    assign ibus_req  = !rst && !jump_en && (credit < 3'd2);
    assign ibus_addr = pc;

    assign hs       = ibus_req && ibus_gnt;
    assign rsp      = ibus_rvalid && (outst != 2'd0);
    assign rsp_keep = rsp && (drop == 2'd0) && !jump_en;
    assign pop      = inst_valid_o && !hold_en && !jump_en;

    assign inst_valid_o = (fifo_count != 2'd0);
    assign inst_o       = inst_valid_o ? fifo_head[31:0] : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? fifo_head[AW+31:32] : '0;

    ifu_buf #(.W(AW)) u_addr_q (
        .clk   (clk),
        .rst   (rst),
        .push  (hs),
        .pop   (rsp_keep),
        .clear (jump_en),
        .din   (pc),
        .count (aq_count),
        .head  (aq_head)
    );

    ifu_buf #(.W(AW + 32)) u_inst_q (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (pop),
        .clear (jump_en),
        .din   ({aq_head, ibus_rdata}),
        .count (fifo_count),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= RESET_PC;
            drop <= 2'd0;
        end else if (jump_en) begin
            pc   <= jump_addr & ~AW'(3);
            drop <= outst - {1'b0, rsp};
        end else begin
            if (hs) pc <= pc + AW'(4);
            if (rsp && (drop != 2'd0)) drop <= drop - 2'd1;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: queue-based reference model checked every cycle, a
// sequential-PC scoreboard on consumed pairs, and directed literal checks.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        hold_en = 1'b0;
    logic        ibus_gnt = 1'b0;
    logic        ibus_rvalid = 1'b0;
    logic [31:0] ibus_rdata = 32'h0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    ifu_fetch #(.AW(32), .RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en      (jump_en),
        .jump_addr    (jump_addr),
        .hold_en      (hold_en),
        .ibus_req     (ibus_req),
        .ibus_addr    (ibus_addr),
        .ibus_gnt     (ibus_gnt),
        .ibus_rvalid  (ibus_rvalid),
        .ibus_rdata   (ibus_rdata),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    // Memory: in-order responses, each 1..4 cycles after its grant.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t bq[$];
    int cyc = 0;
    bit bus_rand = 1'b0;
    int bus_dly = 1;

    always @(posedge clk) begin
        pend_t p;
        cyc++;
        if (rst) begin
            bq.delete();
        end else begin
            if (ibus_rvalid) bq.delete(0);
            if (ibus_req && ibus_gnt) begin
                p.addr = ibus_addr;
                p.due  = cyc - 1 + (bus_rand ? int'($urandom_range(1, 4)) : bus_dly);
                bq.push_back(p);
            end
        end
        #1;
        ibus_gnt = bus_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (!rst && bq.size() > 0 && bq[0].due <= cyc) begin
            ibus_rvalid = 1'b1;
            ibus_rdata  = mem_word(bq[0].addr);
        end else begin
            ibus_rvalid = 1'b0;
            ibus_rdata  = 32'h0;
        end
    end

    // Reference model: live outstanding addresses, a stale count, and the
    // buffered pairs, updated from the rules of the fetch stage.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
    } pair_t;
    pair_t       m_fifo[$];
    logic [31:0] m_oq[$];
    int          m_drop = 0;
    logic [31:0] m_pc = RPC;

    function automatic int m_used();
        return m_oq.size() + m_drop + m_fifo.size();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            m_oq.delete();
            m_drop = 0;
            m_pc   = RPC;
        end else begin
            int    mo;
            bit    mreq;
            pair_t pr;
            mo   = m_oq.size() + m_drop;
            mreq = !jump_en && (m_used() < 2);
            if (jump_en) begin
                m_drop = (ibus_rvalid && mo > 0) ? mo - 1 : mo;
                m_oq.delete();
                m_fifo.delete();
                m_pc = {jump_addr[31:2], 2'b00};
            end else begin
                if (m_fifo.size() > 0 && !hold_en) m_fifo.delete(0);
                if (ibus_rvalid && mo > 0) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        pr.addr = m_oq[0];
                        pr.inst = ibus_rdata;
                        m_fifo.push_back(pr);
                        m_oq.delete(0);
                    end
                end
                if (mreq && ibus_gnt) begin
                    m_oq.push_back(m_pc);
                    m_pc += 32'd4;
                end
            end
        end
    end

    logic [31:0] sb_next = RPC;

    always @(negedge clk) begin
        bit er;
        bit ev;
        if (chk_on) begin
            er = !rst && !jump_en && (m_used() < 2);
            ev = m_fifo.size() > 0;
            chk("ibus_req", 32'(ibus_req), 32'(er));
            chk("ibus_addr", ibus_addr, m_pc);
            chk("inst_valid_o", 32'(inst_valid_o), 32'(ev));
            chk("inst_o", inst_o, ev ? m_fifo[0].inst : INST_NOP);
            chk("inst_addr_o", inst_addr_o, ev ? m_fifo[0].addr : 32'h0);
            if (rst) begin
                sb_next = RPC;
            end else if (jump_en) begin
                sb_next = {jump_addr[31:2], 2'b00};
            end else if (inst_valid_o && !hold_en) begin
                chk("sb_pc", inst_addr_o, sb_next);
                chk("sb_inst", inst_o, mem_word(sb_next));
                sb_next += 32'd4;
                n_pop++;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_req"}, 32'(ibus_req), 32'h0);
        chk({tag, "_ibus_addr"}, ibus_addr, 32'h0000_0000);
        chk({tag, "_valid"}, 32'(inst_valid_o), 32'h0);
        chk({tag, "_inst"}, inst_o, 32'h0000_0013);
        chk({tag, "_inst_addr"}, inst_addr_o, 32'h0);
    endtask

    initial begin
        int pop0;
        bit seen;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        @(negedge clk);
        reset_chk("rst");

        // Streaming from reset with a 1-cycle memory.
        next(); rst = 1'b0;
        @(negedge clk);
        chk("c0_req", 32'(ibus_req), 32'h1);
        chk("c0_addr", ibus_addr, 32'h0);
        next();
        next();
        @(negedge clk);
        chk("c2_valid", 32'(inst_valid_o), 32'h1);
        chk("c2_addr", inst_addr_o, 32'h0);
        chk("c2_inst", inst_o, 32'h5A00_0000);
        chk("c2_req", 32'(ibus_req), 32'h0);
        next();
        @(negedge clk);
        chk("c3_addr", inst_addr_o, 32'h4);

        // Hold for five cycles: credits fill up and the request drops.
        repeat (4) next();
        hold_en = 1'b1;
        repeat (3) next();
        @(negedge clk);
        chk("hold_req", 32'(ibus_req), 32'h0);
        chk("hold_valid", 32'(inst_valid_o), 32'h1);
        next();
        next(); hold_en = 1'b0;
        repeat (10) next();

        // Jump while two fetches are outstanding on a slow memory.
        rst = 1'b1; bus_dly = 4;
        next();
        next(); rst = 1'b0;
        next();
        next(); jump_en = 1'b1; jump_addr = 32'h0000_0102;
        @(negedge clk);
        chk("j_req", 32'(ibus_req), 32'h0);
        next(); jump_en = 1'b0;
        @(negedge clk);
        chk("j_pc", ibus_addr, 32'h0000_0100);
        chk("j_valid", 32'(inst_valid_o), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            next();
            @(negedge clk);
            seen = inst_valid_o;
        end
        chk("j_wait", 32'(seen), 32'h1);
        chk("j_first_addr", inst_addr_o, 32'h0000_0100);
        chk("j_first_inst", inst_o, 32'h5A00_0100);

        // Jump, response and hold all in the same cycle.
        next(); rst = 1'b1; bus_dly = 1;
        next();
        next(); rst = 1'b0;
        next();
        next(); jump_en = 1'b1; hold_en = 1'b1; jump_addr = 32'h0000_0200;
        @(negedge clk);
        chk("jr_valid", 32'(inst_valid_o), 32'h1);
        next(); jump_en = 1'b0; hold_en = 1'b0;
        @(negedge clk);
        chk("jr_req", 32'(ibus_req), 32'h1);
        chk("jr_addr", ibus_addr, 32'h0000_0200);
        chk("jr_valid2", 32'(inst_valid_o), 32'h0);
        next();
        next();
        @(negedge clk);
        chk("jr_out_valid", 32'(inst_valid_o), 32'h1);
        chk("jr_out_addr", inst_addr_o, 32'h0000_0200);

        // Random grant/response timing, holds, jumps and one mid-stream reset.
        bus_rand = 1'b1;
        pop0 = n_pop;
        for (int i = 0; i < 20000 && (n_pop - pop0) < 1000; i++) begin
            next();
            if (i == 1500) begin
                jump_en = 1'b0; hold_en = 1'b0; rst = 1'b1;
                @(negedge clk);
                reset_chk("mid_rst");
                next();
                next(); rst = 1'b0;
                @(negedge clk);
                chk("mid_rst_req", 32'(ibus_req), 32'h1);
                chk("mid_rst_addr", ibus_addr, RPC);
            end else begin
                hold_en   = ($urandom_range(0, 4) == 0);
                jump_en   = ($urandom_range(0, 149) == 0);
                jump_addr = $urandom;
            end
        end
        chk("rand_pops", 32'((n_pop - pop0) >= 1000), 32'h1);

        next(); jump_en = 1'b0; hold_en = 1'b0;
        next();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage of the RV32 core: owns the PC, issues in-order word fetches on the instruction bus and buffers up to two responses. It presents one {pc, instruction} pair per cycle to the IF/ID pipeline register. On a jump it redirects the PC and drops every stale fetch, both buffered and in flight. It is the stage directly upstream of the IF/ID `gen_pipe_dff` instances, and consumes the same `hold_en` that drives them.

## Interface
- `AW`, 32, address/PC width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `jump_en`  in  1  redirect request from EX/ctrl
- `jump_addr`  in  AW  redirect target; bits [1:0] forced to 0
- `hold_en`  in  1  downstream stall; output pair not consumed this cycle
- `ibus_req`  out  1  fetch request valid
- `ibus_addr`  out  AW  fetch word address
- `ibus_gnt`  in  1  request accepted this cycle (req & gnt = handshake)
- `ibus_rvalid`  in  1  response valid; in order, at least 1 cycle after grant
- `ibus_rdata`  in  32  response instruction
- `inst_valid_o`  out  1  output pair valid
- `inst_o`  out  32  instruction; `INST_NOP` (32'h0000_0013) when not valid
- `inst_addr_o`  out  AW  PC of `inst_o`; 0 when not valid

## Operation
- State:
  - `pc`: next address to request.
  - `outst` (0..2): granted requests with no response yet.
  - `drop` (0..2): in-flight responses to discard.
  - 2-entry FIFO of {pc, inst}.
- Issue rule:
  - `ibus_req = !rst && !jump_en && (outst + fifo_count) < 2`, with `ibus_addr = pc`.
  - On `req & gnt`: `pc <= pc + 4`, `outst` +1.
  - The credit limit guarantees FIFO space for every response, so responses are never back-pressured.
- Response handling:
  - On `rvalid`, `outst` −1.
  - If `drop != 0`: `drop` −1 and the data is discarded.
  - Otherwise push {address of the oldest outstanding fetch, `rdata`} into the FIFO.
  - A second small 2-entry address queue, or a pc-minus-offset calculation, tracks response addresses.
- Output:
  - FIFO head drives `inst_o`/`inst_addr_o`.
  - `inst_valid_o = fifo_count != 0`.
  - Pop when `inst_valid_o && !hold_en`.
- Jump (`jump_en = 1`):
  - `pc <= {jump_addr[AW-1:2], 2'b00}`.
  - FIFO cleared.
  - `drop <= outst - (rvalid ? 1 : 0)`; a response arriving in the same cycle is discarded.
  - `ibus_req = 0` that cycle.
  - Jump has priority over `hold_en`, and over pop/push in the same cycle.
- `rvalid` with `outst == 0` is a protocol error. Ignore it; optional assertion.
- Arithmetic: `pc + 4` wraps modulo 2^AW.

## Timing
- During reset:
  - `ibus_req = 0`, `ibus_addr = RESET_PC`.
  - `inst_valid_o = 0`, `inst_o = INST_NOP`, `inst_addr_o = 0`.
  - `pc = RESET_PC`, `outst = drop = 0`, FIFO empty.
- First cycle after reset deassertion: `ibus_req = 1`, `ibus_addr = RESET_PC`.
- Latency:
  - Grant at cycle T, `rvalid` at T+1 earliest.
  - `inst_valid_o` at T+2, because the FIFO is registered.
- Throughput: with 1-cycle memory and no hold, one instruction per cycle in steady state.
- After `jump_en` at cycle J: first request at `jump_addr` in J+1, and no stale pair is ever visible after J.
- `hold_en` held: head stable. At most 2 buffered plus 0 outstanding, then `ibus_req` drops.
- Reset mid-fetch: all counters and the FIFO clear immediately. Responses to pre-reset grants are the bus's responsibility (bus is reset together with the core).

## Structure
- `INST_NOP`, `RESET_PC` default and the `AW` default live in `defines.v`, next to `RST`.
- Sub-module `ifu_buf`: parameterised 2-entry synchronous FIFO (width AW+32) with push, pop, clear, count, and head outputs. It is reused for the address queue.

## Test plan
- Reset release, always-grant, 1-cycle memory returning `rdata = addr`:
  - `inst_addr_o` sequence 0, 4, 8, … with `inst_valid_o` continuous from cycle 2.
  - `inst_o = inst_addr_o`.
- `hold_en = 1` for 5 cycles mid-stream:
  - Head stable, `ibus_req` low after 2 credits are used.
  - Resumes with no skipped or duplicated PC.
- `jump_en` with `jump_addr = 32'h0000_0102` while 2 fetches are outstanding:
  - Both stale responses are discarded.
  - Next valid `inst_addr_o = 32'h0000_0100`.
- `jump_en` in the same cycle as `rvalid` and `hold_en`: that response is dropped, the FIFO is cleared, and the next request is to the jump target.
- Random `gnt`/`rvalid` delays of 1–4 cycles over 1000 fetches: a scoreboard confirms in-order, complete, duplicate-free PCs, and `outst + fifo_count ≤ 2` always.
- Assert `rst` mid-stream: all outputs at reset values in the same cycle; fetch restarts at `RESET_PC`.
